run_ctrl: RTL

Run controller that sequences the single-cycle core through one program execution per request. It sits between the external `req`/`done` handshake and the core. It holds the core in reset, releases it at a selected start address, and gates execution with `core_en`. It detects the halt address on `prog_ctr`, enforces a cycle watchdog, drains for a fixed number of cycles, then reports `done`, the cycle count and a timeout flag.

---
 rtl/run_ctrl_if.sv | 26 ++
 rtl/run_ctrl.sv | 76 +++++++
 2 files changed

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: request/done handshake and core control bundle between host, run_ctrl and the core.
interface run_ctrl_if #(
    parameter int D  = 12,
    parameter int CW = 16
);
    logic          req;
    logic [1:0]    prog_sel;
    logic [D-1:0]  prog_ctr;
    logic          core_rst;
    logic          core_en;
    logic [D-1:0]  start_pc;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cyc_cnt;

    modport slave (
        input  req, prog_sel, prog_ctr,
        output core_rst, core_en, start_pc, busy, done, timeout, cyc_cnt
    );

    modport master (
        output req, prog_sel, prog_ctr,
        input  core_rst, core_en, start_pc, busy, done, timeout, cyc_cnt
    );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: sequences one core program run per request (reset hold, run with watchdog, drain, done).
module run_ctrl #(
    parameter int          D           = 12,
    parameter int          HALT_PC     = 128,
    parameter int          PROG_STRIDE = 256,
    parameter int          RST_CYC     = 2,
    parameter int          DRAIN_CYC   = 2,
    parameter int          CW          = 16,
    parameter logic [31:0] TMO_CYC     = 32'h0000_FFF0
) (
    input logic        clk,
    input logic        reset,
    run_ctrl_if.slave  bus
);
    localparam int PMAX = (RST_CYC > DRAIN_CYC) ? RST_CYC : DRAIN_CYC;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

    state_t        r_state, w_next;
    logic [PW-1:0] r_ph;
    logic [CW-1:0] r_cyc, w_inc;
    logic [D-1:0]  r_spc;
    logic          r_tmo, r_arm;
    logic          w_start, w_halt, w_tmo_hit;

    assign w_inc     = &r_cyc ? r_cyc : r_cyc + CW'(1);
    assign w_halt    = bus.prog_ctr == D'(HALT_PC);
    assign w_tmo_hit = w_inc == CW'(TMO_CYC);
    // A start needs the re-arm bit so a req left high after DONE cannot retrigger
    assign w_start   = r_state == IDLE && bus.req && r_arm;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? INIT : IDLE;
            INIT:    w_next = !bus.req ? IDLE : (r_ph == PW'(RST_CYC - 1)) ? RUN : INIT;
            RUN:     w_next = !bus.req ? IDLE : (w_halt || w_tmo_hit) ? DRAIN : RUN;
            DRAIN:   w_next = !bus.req ? IDLE : (r_ph == PW'(DRAIN_CYC - 1)) ? DONE : DRAIN;
            DONE:    w_next = !bus.req ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_cyc   <= '0;
            r_spc   <= '0;
            r_tmo   <= 1'b0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ph    <= (r_state != w_next) ? '0 : r_ph + PW'(1);
            r_arm   <= w_start ? 1'b0 : (r_state == IDLE && !bus.req) ? 1'b1 : r_arm;
            if (w_start) begin
                r_spc <= D'(32'(bus.prog_sel) * PROG_STRIDE);
                r_cyc <= '0;
                r_tmo <= 1'b0;
            end
            if (r_state == RUN) begin
                r_cyc <= w_inc;
                if (bus.req && !w_halt && w_tmo_hit) r_tmo <= 1'b1;
            end
        end
    end

    assign bus.core_rst = r_state == IDLE || r_state == INIT;
    assign bus.core_en  = r_state == RUN;
    assign bus.busy     = r_state == INIT || r_state == RUN || r_state == DRAIN;
    assign bus.done     = r_state == DONE;
    assign bus.start_pc = r_spc;
    assign bus.timeout  = r_tmo;
    assign bus.cyc_cnt  = r_cyc;
endmodule
